// File: rtl/ann_pkg.sv
// Shared sizes, derived stream word counts and FSM encoding for the kd-tree
// approximate-nearest-neighbour front end.
package ann_pkg;
  localparam int DATA_WIDTH  = 11;
  localparam int PATCH_SIZE  = 5;
  localparam int LEAF_SIZE   = 8;
  localparam int NUM_ROWS    = 26;
  localparam int NUM_COLS    = 19;
  localparam int NUM_QUERYS  = NUM_ROWS * NUM_COLS;
  localparam int NUM_LEAVES  = 64;
  localparam int NUM_NODES   = NUM_LEAVES - 1;
  localparam int ADDR_WIDTH  = $clog2(NUM_LEAVES);
  localparam int FIFO_DEPTH  = 4;
  localparam int IDX_WIDTH   = 3;
  localparam int RD_AW       = 13;
  localparam int Q_WIDTH     = $clog2(NUM_QUERYS);
  localparam int NODE_WORDS  = NUM_NODES * 2;
  localparam int LEAF_WORDS  = NUM_LEAVES * LEAF_SIZE * (PATCH_SIZE + 1);
  localparam int QUERY_WORDS = NUM_QUERYS * PATCH_SIZE;

  typedef enum logic [2:0] {
    IDLE, LOAD_NODES, LOAD_LEAVES, LOAD_QUERY, READY, SEARCH, DONE
  } state_e;

  // Split indices beyond the patch are folded onto its last element.
  function automatic logic [IDX_WIDTH-1:0] clamp_idx(input logic [DATA_WIDTH-1:0] w);
    logic [IDX_WIDTH-1:0] v;
    v = w[IDX_WIDTH-1:0];
    return (v >= IDX_WIDTH'(PATCH_SIZE)) ? IDX_WIDTH'(PATCH_SIZE - 1) : v;
  endfunction
endpackage

// File: rtl/ann_kdtree_top_if.sv
// Stream-in and debug-read bus of the kd-tree front end.
interface ann_kdtree_top_if;
  import ann_pkg::*;
  logic                  in_fifo_wenq;
  logic [DATA_WIDTH-1:0] in_fifo_wdata;
  logic                  in_fifo_wfull_n;
  logic [1:0]            rd_sel;
  logic [RD_AW-1:0]      rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output in_fifo_wenq, in_fifo_wdata, rd_sel, rd_addr,
    input  in_fifo_wfull_n, rd_data
  );
  modport slave (
    input  in_fifo_wenq, in_fifo_wdata, rd_sel, rd_addr,
    output in_fifo_wfull_n, rd_data
  );
endinterface

// File: rtl/ann_kdtree_top_sync_fifo.sv
// Single-clock FIFO with registered not-full flag; a push while full is taken
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wenq_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             wfull_n_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] rdata_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic             wfull_n_q;
  logic             push, pop;

  assign empty_o   = (count_q == '0);
  assign pop       = pop_i && !empty_o;
  assign push      = wenq_i && (wfull_n_q || pop);
  assign wfull_n_o = wfull_n_q;
  assign rdata_o   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (PW+1)'(1);
    else if (pop && !push) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wfull_n_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q   <= count_d;
      wfull_n_q <= (count_d != (PW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/ann_kdtree_top.sv
// Loads kd-tree nodes, leaf patches and query patches from one word stream,
// then walks the tree one level per cycle to find each query's leaf.
module ann_kdtree_top
  import ann_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_kdtree,
  input  logic               fsm_start,
  ann_kdtree_top_if.slave    bus,
  output logic               loaded,
  output logic               busy,
  output logic               done
);
  state_e                 state_q;
  logic [RD_AW-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0]  node_q;
  logic [Q_WIDTH-1:0]     qry_q;
  logic                   loaded_q, busy_q, done_q;

  logic                   fifo_empty, fifo_pop;
  logic [DATA_WIDTH-1:0]  fifo_rdata;

  logic [IDX_WIDTH-1:0]          idx_mem    [NUM_NODES];
  logic signed [DATA_WIDTH-1:0]  med_mem    [NUM_NODES];
  logic [DATA_WIDTH-1:0]         leaf_mem   [LEAF_WORDS];
  logic [DATA_WIDTH-1:0]         query_mem  [QUERY_WORDS];
  logic [ADDR_WIDTH-1:0]         result_mem [NUM_QUERYS];

  logic                          is_load, node_wr, leaf_wr, query_wr, res_wr;
  logic [11:0]                   q_addr;
  logic signed [DATA_WIDTH-1:0]  q_val;
  logic                          go_left, at_leaf, last_query;
  logic [ADDR_WIDTH:0]           next_node;
  logic [ADDR_WIDTH-1:0]         leaf_id;
  logic [DATA_WIDTH-1:0]         rd_data_d;

  assign is_load  = (state_q == LOAD_NODES) || (state_q == LOAD_LEAVES) || (state_q == LOAD_QUERY);
  assign fifo_pop = is_load && !fifo_empty;
  assign node_wr  = fifo_pop && (state_q == LOAD_NODES);
  assign leaf_wr  = fifo_pop && (state_q == LOAD_LEAVES);
  assign query_wr = fifo_pop && (state_q == LOAD_QUERY);

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wenq_i    (bus.in_fifo_wenq),
    .wdata_i   (bus.in_fifo_wdata),
    .wfull_n_o (bus.in_fifo_wfull_n),
    .pop_i     (fifo_pop),
    .empty_o   (fifo_empty),
    .rdata_o   (fifo_rdata)
  );

  // One tree level per cycle: signed compare, >= takes the right child.
  assign q_addr     = 12'(qry_q) * 12'd5 + 12'(idx_mem[node_q]);
  assign q_val      = query_mem[q_addr];
  assign go_left    = q_val < med_mem[node_q];
  assign next_node  = {node_q, 1'b0} + (go_left ? 7'd1 : 7'd2);
  assign at_leaf    = next_node >= 7'(NUM_NODES);
  assign leaf_id    = ADDR_WIDTH'(next_node - 7'(NUM_NODES));
  assign last_query = qry_q == Q_WIDTH'(NUM_QUERYS - 1);
  assign res_wr     = (state_q == SEARCH) && at_leaf;

  always_ff @(posedge clk) begin
    if (node_wr) begin
      if (!cnt_q[0]) idx_mem[cnt_q[6:1]] <= clamp_idx(fifo_rdata);
      else           med_mem[cnt_q[6:1]] <= fifo_rdata;
    end
    if (leaf_wr)  leaf_mem[cnt_q[11:0]]  <= fifo_rdata;
    if (query_wr) query_mem[cnt_q[11:0]] <= fifo_rdata;
    if (res_wr)   result_mem[qry_q]      <= leaf_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      node_q   <= '0;
      qry_q    <= '0;
      loaded_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (load_kdtree) begin
      state_q  <= LOAD_NODES;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        LOAD_NODES: if (fifo_pop) begin
          if (cnt_q == RD_AW'(NODE_WORDS - 1)) begin
            cnt_q   <= '0;
            state_q <= LOAD_LEAVES;
          end else cnt_q <= cnt_q + RD_AW'(1);
        end
        LOAD_LEAVES: if (fifo_pop) begin
          if (cnt_q == RD_AW'(LEAF_WORDS - 1)) begin
            cnt_q   <= '0;
            state_q <= LOAD_QUERY;
          end else cnt_q <= cnt_q + RD_AW'(1);
        end
        LOAD_QUERY: if (fifo_pop) begin
          if (cnt_q == RD_AW'(QUERY_WORDS - 1)) begin
            cnt_q    <= '0;
            state_q  <= READY;
            loaded_q <= 1'b1;
            busy_q   <= 1'b0;
          end else cnt_q <= cnt_q + RD_AW'(1);
        end
        READY, DONE: if (fsm_start) begin
          state_q <= SEARCH;
          node_q  <= '0;
          qry_q   <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        SEARCH: begin
          if (at_leaf) begin
            node_q <= '0;
            if (last_query) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else qry_q <= qry_q + Q_WIDTH'(1);
          end else node_q <= next_node[ADDR_WIDTH-1:0];
        end
        default: state_q <= state_q;
      endcase
    end
  end

  // Node reads use stream addressing: even = split index, odd = median.
  always_comb begin
    rd_data_d = '0;
    case (bus.rd_sel)
      2'd0: if (bus.rd_addr < RD_AW'(NODE_WORDS))
              rd_data_d = bus.rd_addr[0] ? med_mem[bus.rd_addr[6:1]]
                                         : DATA_WIDTH'(idx_mem[bus.rd_addr[6:1]]);
      2'd1: if (bus.rd_addr < RD_AW'(LEAF_WORDS))  rd_data_d = leaf_mem[bus.rd_addr[11:0]];
      2'd2: if (bus.rd_addr < RD_AW'(QUERY_WORDS)) rd_data_d = query_mem[bus.rd_addr[11:0]];
      default: if (bus.rd_addr < RD_AW'(NUM_QUERYS))
              rd_data_d = DATA_WIDTH'(result_mem[bus.rd_addr[Q_WIDTH-1:0]]);
    endcase
  end

  assign bus.rd_data = rd_data_d;
  assign loaded      = loaded_q;
  assign busy        = busy_q;
  assign done        = done_q;
endmodule

// File: tb/tb_ann_kdtree_top.sv
// Directed-sequence bench for ann_kdtree_top with randomized contents checked
// against a software tree walk.
module tb_ann_kdtree_top;
  import ann_pkg::*;

  logic clk = 1'b0;
  logic rst, load_kdtree, fsm_start;
  logic loaded, busy, done;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_WIDTH-1:0] node_w  [NODE_WORDS];
  logic [DATA_WIDTH-1:0] leaf_w  [LEAF_WORDS];
  logic [DATA_WIDTH-1:0] query_w [QUERY_WORDS];
  logic [DATA_WIDTH-1:0] stream_q [$];

  ann_kdtree_top_if bus();

  ann_kdtree_top dut (
    .clk         (clk),
    .rst         (rst),
    .load_kdtree (load_kdtree),
    .fsm_start   (fsm_start),
    .bus         (bus),
    .loaded      (loaded),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_leaf(int q);
    int n, nx, idx, v, m;
    n = 0;
    for (int lvl = 0; lvl < 64; lvl++) begin
      idx = int'(node_w[2*n] & 11'h7);
      if (idx >= PATCH_SIZE) idx = PATCH_SIZE - 1;
      v = $signed(query_w[q*PATCH_SIZE + idx]);
      m = $signed(node_w[2*n + 1]);
      nx = (v < m) ? 2*n + 1 : 2*n + 2;
      if (nx >= NUM_NODES) return nx - NUM_NODES;
      n = nx;
    end
    return -1;
  endfunction

  function automatic int exp_node(int a);
    int idx;
    if (a % 2 == 1) return int'(node_w[a]);
    idx = int'(node_w[a] & 11'h7);
    return (idx >= PATCH_SIZE) ? PATCH_SIZE - 1 : idx;
  endfunction

  task automatic rd(input logic [1:0] s, input int a, output logic [DATA_WIDTH-1:0] d);
    bus.rd_sel  = s;
    bus.rd_addr = RD_AW'(a);
    #1;
    d = bus.rd_data;
  endtask

  task automatic build_stream();
    stream_q = {};
    for (int i = 0; i < NODE_WORDS; i++)  stream_q.push_back(node_w[i]);
    for (int i = 0; i < LEAF_WORDS; i++)  stream_q.push_back(leaf_w[i]);
    for (int i = 0; i < QUERY_WORDS; i++) stream_q.push_back(query_w[i]);
  endtask

  task automatic push_word(input logic [DATA_WIDTH-1:0] w);
    int t;
    t = 0;
    while (!bus.in_fifo_wfull_n && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) chk("push_wait_timeout", 32'(t), 32'd49);
    bus.in_fifo_wenq  = 1'b1;
    bus.in_fifo_wdata = w;
    step();
    bus.in_fifo_wenq  = 1'b0;
    step();
  endtask

  task automatic load_stream(input int first, input int start_at);
    for (int i = first; i < stream_q.size(); i++) begin
      if (i == start_at) begin
        fsm_start = 1'b1;
        step();
        fsm_start = 1'b0;
        chk("start_in_load_busy", 32'(busy), 32'd1);
        chk("start_in_load_done", 32'(done), 32'd0);
        chk("start_in_load_loaded", 32'(loaded), 32'd0);
      end
      push_word(stream_q[i]);
    end
  endtask

  task automatic wait_loaded();
    int t;
    t = 0;
    while (!loaded && t < 40) begin
      step();
      t++;
    end
    chk("loaded_rise", 32'(loaded), 32'd1);
    chk("loaded_busy", 32'(busy), 32'd0);
    chk("loaded_done", 32'(done), 32'd0);
  endtask

  task automatic run_search(input string tag);
    int cyc;
    logic [DATA_WIDTH-1:0] d;
    fsm_start = 1'b1;
    step();
    fsm_start = 1'b0;
    chk("search_busy", 32'(busy), 32'd1);
    chk("search_done_low", 32'(done), 32'd0);
    cyc = 0;
    while (!done && cyc < 4000) begin
      step();
      cyc++;
    end
    chk("search_latency", 32'(cyc), 32'(NUM_QUERYS * ADDR_WIDTH));
    chk("search_done", 32'(done), 32'd1);
    chk("search_idle", 32'(busy), 32'd0);
    chk("search_loaded", 32'(loaded), 32'd1);
    for (int q = 0; q < NUM_QUERYS; q++) begin
      rd(2'd3, q, d);
      chk("result", 32'(d), 32'(model_leaf(q)));
    end
    step();
    $display("search %s: %0d cycles, results compared", tag, cyc);
  endtask

  initial begin
    logic [DATA_WIDTH-1:0] d;
    int a, v;
    rst = 1'b1;
    load_kdtree = 1'b0;
    fsm_start = 1'b0;
    bus.in_fifo_wenq = 1'b0;
    bus.in_fifo_wdata = '0;
    bus.rd_sel = '0;
    bus.rd_addr = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_wfull_n", 32'(bus.in_fifo_wfull_n), 32'd1);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    $display("reset released");

    // Tree A: all medians 0, every split index folds to 0.
    for (int n = 0; n < NUM_NODES; n++) begin
      node_w[2*n]   = 11'($urandom) & 11'h7F8;
      node_w[2*n+1] = '0;
    end
    for (int i = 0; i < LEAF_WORDS; i++)  leaf_w[i]  = 11'($urandom);
    for (int i = 0; i < QUERY_WORDS; i++) query_w[i] = 11'($urandom);
    query_w[0] = 11'h7FB;
    query_w[5] = 11'd5;
    build_stream();

    for (int i = 0; i < 4; i++) begin
      bus.in_fifo_wenq  = 1'b1;
      bus.in_fifo_wdata = stream_q[i];
      step();
      chk("fifo_fill_wfull_n", 32'(bus.in_fifo_wfull_n), (i < 3) ? 32'd1 : 32'd0);
    end
    bus.in_fifo_wdata = 11'h555;
    step();
    bus.in_fifo_wenq = 1'b0;
    chk("fifo_drop_wfull_n", 32'(bus.in_fifo_wfull_n), 32'd0);
    repeat (3) step();
    chk("fifo_hold_idle", 32'(bus.in_fifo_wfull_n), 32'd0);
    chk("fifo_hold_busy", 32'(busy), 32'd0);
    $display("fifo filled with 4 words, 5th dropped");

    load_kdtree = 1'b1;
    step();
    load_kdtree = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_loaded", 32'(loaded), 32'd0);
    load_stream(4, -1);
    wait_loaded();
    $display("load A complete");

    for (int i = 0; i < 6; i++) begin
      rd(2'd0, i, d);
      chk("rd_node_head", 32'(d), 32'(exp_node(i)));
    end
    rd(2'd0, NODE_WORDS - 1, d);   chk("rd_node_last", 32'(d), 32'(exp_node(NODE_WORDS - 1)));
    rd(2'd0, NODE_WORDS, d);       chk("rd_node_oob", 32'(d), 32'd0);
    rd(2'd1, 0, d);                chk("rd_leaf_first", 32'(d), 32'(leaf_w[0]));
    rd(2'd1, LEAF_WORDS - 1, d);   chk("rd_leaf_last", 32'(d), 32'(leaf_w[LEAF_WORDS-1]));
    rd(2'd1, LEAF_WORDS, d);       chk("rd_leaf_oob", 32'(d), 32'd0);
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(0, LEAF_WORDS - 1);
      rd(2'd1, a, d);
      chk("rd_leaf_rand", 32'(d), 32'(leaf_w[a]));
    end
    rd(2'd2, 0, d);                chk("rd_query_neg", 32'(d), 32'h7FB);
    rd(2'd2, QUERY_WORDS - 1, d);  chk("rd_query_last", 32'(d), 32'(query_w[QUERY_WORDS-1]));
    rd(2'd2, QUERY_WORDS, d);      chk("rd_query_oob", 32'(d), 32'd0);
    rd(2'd3, NUM_QUERYS, d);       chk("rd_result_oob", 32'(d), 32'd0);
    step();

    run_search("A");
    rd(2'd3, 0, d); chk("trav_q0_left", 32'(d), 32'd0);
    rd(2'd3, 1, d); chk("trav_q1_right", 32'(d), 32'd63);
    step();

    fsm_start = 1'b1;
    step();
    fsm_start = 1'b0;
    repeat (100) step();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    chk("abort_pre_done", 32'(done), 32'd0);
    load_kdtree = 1'b1;
    step();
    load_kdtree = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_loaded", 32'(loaded), 32'd0);
    $display("search aborted by load_kdtree");

    // Tree B: random split indices (some out of range) and small medians.
    for (int n = 0; n < NUM_NODES; n++) begin
      node_w[2*n] = 11'($urandom);
      v = $urandom_range(0, 40);
      node_w[2*n+1] = 11'(v - 20);
    end
    node_w[0] = 11'd2;
    node_w[1] = 11'd10;
    for (int i = 0; i < LEAF_WORDS; i++) leaf_w[i] = 11'($urandom);
    for (int i = 0; i < QUERY_WORDS; i++) begin
      v = $urandom_range(0, 60);
      query_w[i] = 11'(v - 30);
    end
    query_w[2] = 11'd10;
    build_stream();
    load_stream(0, 1000);
    wait_loaded();
    $display("load B complete");

    rd(2'd0, 0, d);               chk("rd_b_idx0", 32'(d), 32'd2);
    rd(2'd0, 1, d);               chk("rd_b_med0", 32'(d), 32'd10);
    a = $urandom_range(0, NUM_NODES - 1) * 2;
    rd(2'd0, a, d);               chk("rd_b_idx_clamp", 32'(d), 32'(exp_node(a)));
    rd(2'd2, 2, d);               chk("rd_b_q0e2", 32'(d), 32'd10);
    rd(2'd1, LEAF_WORDS - 1, d);  chk("rd_b_leaf_last", 32'(d), 32'(leaf_w[LEAF_WORDS-1]));
    step();

    run_search("B");
    rd(2'd3, 0, d);
    chk("mixed_q0_right", 32'(d >= 11'd32), 32'd1);
    step();

    fsm_start = 1'b1;
    step();
    fsm_start = 1'b0;
    repeat (50) step();
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_loaded", 32'(loaded), 32'd0);
    chk("async_rst_wfull_n", 32'(bus.in_fifo_wfull_n), 32'd1);
    step();
    rst = 1'b0;
    step();
    $display("reset during search");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
